// File: rtl/vga_fb_scheduler.sv
// Shares one single-port framebuffer RAM between display refresh (fixed fetch slots
// keyed to the raster position) and a drawing-engine write port; serialises words to pixels.
module vga_fb_scheduler #(
   parameter int H_ACTIVE = 640,
   parameter int H_TOTAL  = 800,
   parameter int V_ACTIVE = 480,
   parameter int V_TOTAL  = 525,
   parameter int PIX_BITS = 1,
   parameter int WORD_PIX = 8,
   parameter int ADDR_W   = 16
) (
   input  logic                         i_VGA_CLOCK,
   input  logic                         i_rst,
   input  logic [9:0]                   i_Sx,
   input  logic [9:0]                   i_Sy,
   input  logic                         i_de,
   input  logic                         i_hsync,
   input  logic                         i_vsync,
   input  logic                         i_wr_req,
   input  logic [ADDR_W-1:0]            i_wr_addr,
   input  logic [WORD_PIX*PIX_BITS-1:0] i_wr_data,
   output logic                         o_wr_ack,
   output logic [ADDR_W-1:0]            o_mem_addr,
   output logic                         o_mem_re,
   output logic                         o_mem_we,
   output logic [WORD_PIX*PIX_BITS-1:0] o_mem_wdata,
   input  logic [WORD_PIX*PIX_BITS-1:0] i_mem_rdata,
   output logic [PIX_BITS-1:0]          o_pixel,
   output logic                         o_de,
   output logic                         o_hsync,
   output logic                         o_vsync,
   output logic                         o_synced
);

   localparam int WORD_W      = WORD_PIX * PIX_BITS;
   localparam int WPL         = H_ACTIVE / WORD_PIX;
   localparam int FRAME_WORDS = V_ACTIVE * WPL;
   localparam int IDX_W       = $clog2(WORD_PIX);

   typedef enum logic [1:0] {IDLE, FETCH, CAPTURE} slot_state_t;

   slot_state_t         state_reg, state_next;
   logic [ADDR_W-1:0]   word_cnt_reg;
   logic [WORD_W-1:0]   hold_reg;
   logic [WORD_W-1:0]   shift_reg;

   logic [10:0]         sx_ahead;
   logic [10:0]         row_tgt;
   logic                slot_fetch;
   logic                frame_start;
   logic                fetch_go;
   logic                wr_accept;
   logic                wr_in_range;
   logic [ADDR_W-1:0]   fetch_addr;
   logic [IDX_W-1:0]    pix_idx;
   logic                load_shift;
   logic [PIX_BITS-1:0] pixel_next;

   logic [PIX_BITS-1:0] shift_lane [WORD_PIX];
   logic [PIX_BITS-1:0] hold_lane  [WORD_PIX];

   generate
      for (genvar gi = 0; gi < WORD_PIX; gi++) begin : g_lane
         assign shift_lane[gi] = shift_reg[gi*PIX_BITS +: PIX_BITS];
         assign hold_lane[gi]  = hold_reg[gi*PIX_BITS +: PIX_BITS];
      end
   endgenerate

   // Slot decision looks 3 pixels ahead; the word-0 slot lives at the tail of the previous line.
   always_comb begin
      sx_ahead = 11'(i_Sx) + 11'd3;
      row_tgt  = 11'(i_Sy);
      if (sx_ahead >= 11'(H_TOTAL)) begin
         sx_ahead = sx_ahead - 11'(H_TOTAL);
         row_tgt  = (i_Sy == 10'(V_TOTAL - 1)) ? '0 : 11'(i_Sy) + 11'd1;
      end
      slot_fetch  = ((sx_ahead % 11'(WORD_PIX)) == '0) &&
                    (sx_ahead < 11'(H_ACTIVE)) && (row_tgt < 11'(V_ACTIVE));
      frame_start = slot_fetch && (sx_ahead == '0) && (row_tgt == '0);
      fetch_addr  = frame_start ? '0 : word_cnt_reg;
   end

   always_comb begin
      state_next = state_reg;
      fetch_go   = 1'b0;
      wr_accept  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (slot_fetch) begin
               state_next = FETCH;
               fetch_go   = 1'b1;
            end
         end
         FETCH:   state_next = CAPTURE;
         CAPTURE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
      // Display owns the slot-decision cycle; back-to-back writes are spaced by the ack cycle.
      wr_accept = i_wr_req && !o_wr_ack && !slot_fetch;
   end

   assign wr_in_range = (33'(i_wr_addr) < 33'(FRAME_WORDS));

   always_comb begin
      pix_idx    = IDX_W'(i_Sx % 10'(WORD_PIX));
      load_shift = (i_Sx < 10'(H_ACTIVE)) && (i_Sy < 10'(V_ACTIVE)) && (pix_idx == '0);
      pixel_next = '0;
      if (i_de && o_synced)
         pixel_next = load_shift ? hold_lane[pix_idx] : shift_lane[pix_idx];
   end

   always_ff @(posedge i_VGA_CLOCK) begin
      if (i_rst) begin
         state_reg    <= IDLE;
         word_cnt_reg <= '0;
         hold_reg     <= '0;
         shift_reg    <= '0;
         o_wr_ack     <= 1'b0;
         o_mem_addr   <= '0;
         o_mem_re     <= 1'b0;
         o_mem_we     <= 1'b0;
         o_mem_wdata  <= '0;
         o_pixel      <= '0;
         o_de         <= 1'b0;
         o_hsync      <= 1'b0;
         o_vsync      <= 1'b0;
         o_synced     <= 1'b0;
      end else begin
         state_reg <= state_next;
         o_mem_re  <= fetch_go;
         o_mem_we  <= wr_accept && wr_in_range;
         o_wr_ack  <= wr_accept;
         if (fetch_go) begin
            o_mem_addr   <= fetch_addr;
            word_cnt_reg <= fetch_addr + 1'b1;
         end else if (wr_accept) begin
            o_mem_addr  <= i_wr_addr;
            o_mem_wdata <= i_wr_data;
         end
         if (frame_start)
            o_synced <= 1'b1;
         if (state_reg == CAPTURE)
            hold_reg <= i_mem_rdata;
         if (load_shift)
            shift_reg <= hold_reg;
         o_pixel <= pixel_next;
         o_de    <= i_de;
         o_hsync <= i_hsync;
         o_vsync <= i_vsync;
      end
   end

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench for vga_fb_scheduler on a reduced 80x12 raster (64x8 visible, 64 words/frame).
module tb_vga_fb_scheduler;

   localparam int HA = 64, HT = 80, VA = 8, VT = 12, WP = 8, WPL = 8, FW = 64;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [9:0]  i_sx, i_sy;
   logic        de, hs, vs;
   logic        req;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        o_wr_ack, o_mem_re, o_mem_we;
   logic [15:0] o_mem_addr;
   logic [7:0]  o_mem_wdata;
   logic [7:0]  mem_rdata;
   logic [0:0]  o_pixel;
   logic        o_de, o_hsync, o_vsync, o_synced;

   vga_fb_scheduler #(
      .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
      .PIX_BITS(1), .WORD_PIX(WP), .ADDR_W(16)
   ) dut (
      .i_VGA_CLOCK(clk), .i_rst(rst), .i_Sx(i_sx), .i_Sy(i_sy),
      .i_de(de), .i_hsync(hs), .i_vsync(vs),
      .i_wr_req(req), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
      .o_wr_ack(o_wr_ack), .o_mem_addr(o_mem_addr), .o_mem_re(o_mem_re),
      .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata),
      .o_pixel(o_pixel), .o_de(o_de), .o_hsync(o_hsync), .o_vsync(o_vsync),
      .o_synced(o_synced)
   );

   // Framebuffer RAM: word n holds n[7:0] after reset, read data one cycle after the strobe.
   logic [7:0] ram [FW];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FW; i++) ram[i] <= 8'(i);
      end else begin
         if (o_mem_re) mem_rdata <= (int'(o_mem_addr) < FW) ? ram[o_mem_addr[5:0]] : 8'h00;
         if (o_mem_we && int'(o_mem_addr) < FW) ram[o_mem_addr[5:0]] <= o_mem_wdata;
      end
   end

   int          sx, sy;
   int          n_cmp = 0, n_bad = 0;
   logic [7:0]  ref_img [FW];
   logic        exp_synced, exp_ack;
   int          exp_wc;
   int          re_cnt, bad_phase, ack_cnt, ack_in_slot;
   logic        auto_inc, got_ack, cap_we;
   logic [15:0] cap_l1;
   logic        cap_p8, cap_p9;
   logic [7:0]  cap_row0;

   function automatic logic de_f(int x, int y);
      return (x < HA) && (y < VA);
   endfunction
   function automatic logic hs_f(int x);
      return (x >= 66) && (x < 74);
   endfunction
   function automatic logic vs_f(int y);
      return (y == 9);
   endfunction
   function automatic logic fetch_slot(int x, int y);
      int t, row;
      t = x + 3;
      row = y;
      if (t >= HT) begin
         t = t - HT;
         row = (y + 1) % VT;
      end
      return ((t % WP) == 0) && (t < HA) && (row < VA);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      i_sx = 10'(sx);
      i_sy = 10'(sy);
      de   = de_f(sx, sy);
      hs   = hs_f(sx);
      vs   = vs_f(sy);
   endtask

   // One clock: check outputs produced by the inputs applied this cycle, then advance the raster.
   task automatic tick();
      logic slot, ack_now, exp_pix;
      int   a;
      @(posedge clk);
      #1;
      if (rst) begin
         chk("reset_outs", {o_wr_ack, o_mem_addr, o_mem_re, o_mem_we, o_mem_wdata,
                            o_pixel, o_de, o_hsync, o_vsync, o_synced}, 32'h0);
         exp_synced = 1'b0;
         exp_ack    = 1'b0;
         exp_wc     = 0;
      end else begin
         slot    = fetch_slot(sx, sy);
         ack_now = req && !exp_ack && !slot;
         chk("sync_delay", {o_de, o_hsync, o_vsync}, {de_f(sx, sy), hs_f(sx), vs_f(sy)});
         exp_pix = 1'b0;
         if (de_f(sx, sy) && exp_synced) exp_pix = ref_img[sy*WPL + sx/WP][sx%WP];
         chk("pixel", o_pixel, exp_pix);
         if (slot && sx == HT-3 && sy == VT-1) exp_synced = 1'b1;
         chk("synced", o_synced, exp_synced);
         chk("mem_re", o_mem_re, slot);
         if (slot) begin
            a = (sx == HT-3 && sy == VT-1) ? 0 : exp_wc;
            exp_wc = a + 1;
            chk("fetch_addr", o_mem_addr, a);
         end
         chk("re_we_excl", o_mem_re & o_mem_we, 0);
         chk("wr_ack", o_wr_ack, ack_now);
         chk("mem_we", o_mem_we, ack_now && int'(wr_addr) < FW);
         if (ack_now) chk("wr_addr_data", {o_mem_addr, o_mem_wdata}, {wr_addr, wr_data});
         exp_ack = ack_now;
         if (o_mem_re) begin
            re_cnt++;
            if (sx % WP != 5) bad_phase++;
            if (sx == HT-3 && sy == 0) cap_l1 = o_mem_addr;
         end
         if (sy == 0 && sx == 8) cap_p8 = o_pixel;
         if (sy == 0 && sx == 9) cap_p9 = o_pixel;
         if (sy == 0 && sx < 8) cap_row0[sx] = o_pixel;
         if (o_wr_ack) begin
            got_ack = 1'b1;
            cap_we  = o_mem_we;
            ack_cnt++;
            if (slot) ack_in_slot++;
            $display("wr ack addr=%0d data=%02h we=%0b at (%0d,%0d)", wr_addr, wr_data, o_mem_we, sx, sy);
            if (int'(wr_addr) < FW) ref_img[wr_addr[5:0]] = wr_data;
            if (auto_inc) begin
               wr_addr = 16'((int'(wr_addr) + 1) % FW);
               wr_data = wr_addr[7:0];
            end else begin
               req = 1'b0;
            end
         end
      end
      sx++;
      if (sx == HT) begin
         sx = 0;
         sy = (sy + 1) % VT;
      end
      drive();
   endtask

   task automatic run_to(input int tx, input int ty);
      for (int n = 0; n < 2 * HT * VT && !(sx == tx && sy == ty); n++) tick();
   endtask

   initial begin
      int n;
      for (int i = 0; i < FW; i++) ref_img[i] = 8'(i);
      exp_synced = 1'b0; exp_ack = 1'b0; exp_wc = 0;
      re_cnt = 0; bad_phase = 0; ack_cnt = 0; ack_in_slot = 0;
      auto_inc = 1'b0; got_ack = 1'b0; cap_we = 1'b1;
      req = 1'b0; wr_addr = '0; wr_data = '0;

      // Reset mid-line for 5 cycles
      rst = 1'b1; sx = 30; sy = 3; drive();
      repeat (5) tick();
      rst = 1'b0;

      // First frame start after reset
      n = 0;
      while (!exp_synced && n < 2 * HT * VT) begin tick(); n++; end
      chk("synced_rise", o_synced, 1);

      // One full frame of fetches against the n[7:0] image
      re_cnt = 0; bad_phase = 0; cap_l1 = 'x; cap_p8 = 'x; cap_p9 = 'x;
      repeat (HT * VT) tick();
      chk("fetches_per_frame", re_cnt, FW);
      chk("fetch_phase_bad", bad_phase, 0);
      chk("line1_word0_addr", cap_l1, 16'd8);
      chk("pix_8_0", cap_p8, 1);
      chk("pix_9_0", cap_p9, 0);

      // Continuous write requests during active video (data matches RAM contents)
      run_to(0, 2);
      auto_inc = 1'b1; wr_addr = 16'd16; wr_data = 8'd16; req = 1'b1;
      ack_cnt = 0; ack_in_slot = 0;
      repeat (200) tick();
      auto_inc = 1'b0; req = 1'b0;
      chk("ack_rate_ok", ack_cnt >= 75, 1);
      chk("ack_after_slot", ack_in_slot, 0);
      repeat (4) tick();

      // Vertical-blank write of word 0, then see it on the next frame
      run_to(0, 9);
      wr_addr = 16'd0; wr_data = 8'hFF; req = 1'b1; got_ack = 1'b0; n = 0;
      while (!got_ack && n < 10) begin tick(); n++; end
      chk("vblank_ack_latency", got_ack && n <= 2, 1);
      cap_row0 = 'x;
      run_to(8, 0);
      chk("row0_pixels", cap_row0, 8'hFF);

      // Out-of-range write is acked but dropped
      run_to(0, 10);
      wr_addr = 16'd64; wr_data = 8'hAA; req = 1'b1; got_ack = 1'b0; cap_we = 1'b1; n = 0;
      while (!got_ack && n < 10) begin tick(); n++; end
      chk("drop_ack", got_ack, 1);
      chk("drop_we", cap_we, 0);

      // Full frame of delayed sync/DE and pixel checks
      repeat (HT * VT) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_fb_scheduler.md
Name: vga_fb_scheduler

Overview:
- Time-slot scheduler that shares one single-port framebuffer RAM between two users: the display-refresh path driven by core_480's raster position, and a drawing/write requester.
- Display reads are issued in fixed slots tied to i_Sx/i_Sy, so display fetches never miss a pixel deadline. Writes use every other free cycle.
- Fetched words are serialised into pixels aligned to 1-cycle-delayed copies of the core's sync/DE outputs.
- Sits between core_480, the framebuffer RAM and the drawing engine.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_TOTAL, 800, total pixels per line (Sx range 0..H_TOTAL-1)
- V_ACTIVE, 480, visible lines
- V_TOTAL, 525, total lines (Sy range 0..V_TOTAL-1)
- PIX_BITS, 1, bits per pixel
- WORD_PIX, 8, pixels per RAM word; H_ACTIVE divisible by it; minimum 4
- ADDR_W, 16, RAM word-address width; must hold V_ACTIVE*H_ACTIVE/WORD_PIX - 1

Ports:
- i_VGA_CLOCK  in  1  pixel clock, the only clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_Sx  in  10  horizontal position from core_480
- i_Sy  in  10  vertical position from core_480
- i_de, i_hsync, i_vsync  in  1 each  timing from core_480
- i_wr_req  in  1  write request; held until o_wr_ack
- i_wr_addr  in  ADDR_W  write word address
- i_wr_data  in  WORD_PIX*PIX_BITS  write data
- o_wr_ack  out  1  one-cycle pulse; write issued to RAM this cycle
- o_mem_addr  out  ADDR_W  RAM address (registered)
- o_mem_re  out  1  RAM read strobe (registered)
- o_mem_we  out  1  RAM write strobe (registered)
- o_mem_wdata  out  WORD_PIX*PIX_BITS  RAM write data (registered)
- i_mem_rdata  in  WORD_PIX*PIX_BITS  RAM read data, valid the cycle after o_mem_re
- o_pixel  out  PIX_BITS  pixel for the position core_480 showed one cycle earlier
- o_de, o_hsync, o_vsync  out  1 each  i_de/i_hsync/i_vsync delayed 1 cycle
- o_synced  out  1  high once a frame start has been seen since reset

Behaviour:
- Reset, while i_rst=1 at an edge: every output 0; word counter 0; shifter 0; slot FSM IDLE; o_synced 0.
- Reset asserted mid-frame aborts any in-flight fetch or write without ack. The requester must re-present after reset.
- WPL = H_ACTIVE/WORD_PIX (80 at defaults).
- Fetch slot: at an input cycle with i_Sx == (k*WORD_PIX - 3) mod H_TOTAL, for k in 0..WPL-1. The target row is i_Sy for k>0. For k=0 it is (i_Sy+1) mod V_TOTAL, i.e. the slot sits at Sx=H_TOTAL-3 of the previous line. A slot is a fetch only if the target row < V_ACTIVE.
- Slot FSM: IDLE -> FETCH (o_mem_re=1 and o_mem_addr=word counter, cycle Sx=8k-2) -> CAPTURE (i_mem_rdata latched into hold register, cycle 8k-1) -> IDLE. The word counter increments after each fetch.
- Frame start is the k=0 slot with target row 0. At frame start the word counter is reset to 0 and o_synced is set.
- Shifter: on the cycle input Sx = k*WORD_PIX of an active line, the shifter loads the hold register.
- o_pixel is registered from bits [(Sx mod WORD_PIX)*PIX_BITS +: PIX_BITS]. Pixel 0 is the LSBs.
- o_pixel is forced to 0 when the delayed DE is 0 or o_synced is 0.
- Writes are accepted in cycle t iff all of the following hold: i_wr_req=1; o_wr_ack=0; cycle t is not a fetch-slot decision cycle.
- For an accepted write, at t+1: o_mem_we=1, o_mem_addr=i_wr_addr, o_mem_wdata=i_wr_data, o_wr_ack=1.
- Maximum write rate is one per 2 cycles. A write request coinciding with a fetch slot is deferred by at least one cycle; the display always wins.
- o_mem_re and o_mem_we are never high together.
- Write addresses >= V_ACTIVE*WPL are acked with o_mem_we held at 0 (the write is dropped).
- No fetches occur while V_ACTIVE <= target row < V_TOTAL. Writes run at full rate during vertical blank.

Test Plan:
- Reset held 5 cycles mid-line at Sx=300 -> all outputs 0. After release, o_synced rises at Sx=797, Sy=524. Pixels are 0 before that point.
- RAM model with word n = n[7:0], full frame -> o_mem_re pulses exactly 38400 times per frame. Line 1 word 0 is read at address 80. o_pixel at Sx=9, Sy=0 equals bit 1 of 0x01 = 0. All fetches land at Sx ≡ 6 mod 8.
- i_wr_req held continuously during active video -> o_wr_ack roughly every 2 cycles. No ack in the cycle after a slot decision at Sx ≡ 5 mod 8. o_mem_re and o_mem_we never high together.
- Write req addr 0x0000 data 0xFF, issued at Sy=500 -> acked within 2 cycles. Next frame pixels (0..7, 0) = 1.
- Write to addr 38400 -> o_wr_ack=1, o_mem_we=0.
- Delayed sync check -> o_hsync/o_vsync/o_de equal the core outputs delayed 1 cycle across a full frame of 800x525 clocks.
